// File: rtl/seg_scan_driver_if.sv
// Host-side bus of the multiplexed 7-segment scanner: data load strobe in,
// segment/digit drive and frame pulse out.
interface seg_scan_driver_if;
   logic        load;
   logic [31:0] digit_data;
   logic [7:0]  digit_en;
   logic [7:0]  blink_mask;
   logic [6:0]  seg_display;
   logic [7:0]  seg_position;
   logic        frame_done;

   modport master (
      output load, digit_data, digit_en, blink_mask,
      input  seg_display, seg_position, frame_done
   );

   modport slave (
      input  load, digit_data, digit_en, blink_mask,
      output seg_display, seg_position, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit time-multiplexed 7-segment driver with per-slot blanking,
// frame-synchronous double-buffered digit data and per-digit blinking.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned BLANK_CYC    = 2,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input logic               clk,
   input logic               rst,
   seg_scan_driver_if.slave  bus
);

   localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);

   logic [SW-1:0] r_slot;
   logic [2:0]    r_digit;
   logic [FW-1:0] r_frame;

   logic [31:0]   r_pend_data, r_act_data;
   logic [7:0]    r_pend_en,   r_act_en;
   logic [7:0]    r_pend_mask, r_act_mask;

   logic [6:0]    r_seg;
   logic [7:0]    r_pos;
   logic          r_fd;

   logic          w_slot_end;
   logic          w_frame_end;
   logic          w_blink_off;
   logic          w_blank;
   logic          w_lit;
   logic [3:0]    w_nib;
   logic [6:0]    w_code;

   assign w_slot_end  = (r_slot == SW'(SCAN_DIV - 1));
   assign w_frame_end = w_slot_end && (r_digit == 3'd7);
   assign w_blink_off = (r_frame >= FW'(BLINK_FRAMES));
   assign w_nib       = r_act_data[{r_digit, 2'b00} +: 4];

   if (BLANK_CYC == 0) begin : g_noblank
      assign w_blank = 1'b0;
   end else begin : g_blank
      assign w_blank = (r_slot < SW'(BLANK_CYC));
   end

   assign w_lit = !w_blank && r_act_en[r_digit] &&
                  !(r_act_mask[r_digit] && w_blink_off);

   always_comb begin
      w_code = 7'h00;
      case (w_nib)
         4'h0: w_code = 7'h7E;
         4'h1: w_code = 7'h30;
         4'h2: w_code = 7'h6D;
         4'h3: w_code = 7'h79;
         4'h4: w_code = 7'h33;
         4'h5: w_code = 7'h5B;
         4'h6: w_code = 7'h5F;
         4'h7: w_code = 7'h70;
         4'h8: w_code = 7'h7F;
         4'h9: w_code = 7'h7B;
         4'hA: w_code = 7'h77;
         4'hB: w_code = 7'h1F;
         4'hC: w_code = 7'h4E;
         4'hD: w_code = 7'h3D;
         4'hE: w_code = 7'h4F;
         4'hF: w_code = 7'h47;
         default: w_code = 7'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot  <= '0;
         r_digit <= '0;
         r_frame <= '0;
      end else begin
         r_slot <= w_slot_end ? '0 : r_slot + 1'b1;
         if (w_slot_end) r_digit <= r_digit + 1'b1;
         if (w_frame_end)
            r_frame <= (r_frame == FW'(2 * BLINK_FRAMES - 1)) ? '0 : r_frame + 1'b1;
      end
   end

   // Active copies the pre-edge pending value, so a load coinciding with the
   // frame boundary lands in pending only and shows one frame later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend_data <= '0;
         r_pend_en   <= '0;
         r_pend_mask <= '0;
         r_act_data  <= '0;
         r_act_en    <= '0;
         r_act_mask  <= '0;
      end else begin
         if (bus.load) begin
            r_pend_data <= bus.digit_data;
            r_pend_en   <= bus.digit_en;
            r_pend_mask <= bus.blink_mask;
         end
         if (w_frame_end) begin
            r_act_data <= r_pend_data;
            r_act_en   <= r_pend_en;
            r_act_mask <= r_pend_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seg <= '0;
         r_pos <= '1;
         r_fd  <= 1'b0;
      end else begin
         r_seg <= w_lit ? w_code : '0;
         r_pos <= w_lit ? ~(8'b1 << r_digit) : '1;
         r_fd  <= w_frame_end;
      end
   end

   assign bus.seg_display  = r_seg;
   assign bus.seg_position = r_pos;
   assign bus.frame_done   = r_fd;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles per digit slot; legal values are 2 or more.
REQ-002 Parameter BLANK_CYC, default 2: anti-ghosting blank cycles at the start of each slot; legal values are 0 to SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period; legal values are 1 or more.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 load  input  1  one-cycle strobe; captures digit_data, digit_en and blink_mask into the pending registers.
REQ-007 digit_data  input  32  eight hex nibbles; nibble i (bits 4i+3..4i) is the value for digit i.
REQ-008 digit_en  input  8  bit i=1 enables digit i; a disabled digit stays dark.
REQ-009 blink_mask  input  8  bit i=1 makes digit i blink.
REQ-010 seg_display  output  7  segments, active-high; bit6=a, bit5=b, ..., bit0=g.
REQ-011 seg_position  output  8  digit select, active-low; bit i drives digit i.
REQ-012 frame_done  output  1  one-cycle pulse on the last cycle of the digit-7 slot.

Function
REQ-013 Slot counter shall count 0..SCAN_DIV-1 and wrap; digit index shall count 0..7, advancing when the slot counter wraps; digit 7 wraps to 0.
REQ-014 Frame counter shall count 0..2*BLINK_FRAMES-1, incrementing when digit 7's slot ends, and wrap to 0; blink phase is "off" while the count is >= BLINK_FRAMES.
REQ-015 Slot cycles 0..BLANK_CYC-1 shall be blank: seg_position=8'hFF, seg_display=7'h00.
REQ-016 Remaining slot cycles shall drive the current digit i, with seg_position bit i=0 and all others 1, and seg_display=decode(active nibble i).
REQ-017 The digit shall be dark instead (seg_position=8'hFF, seg_display=7'h00) if active digit_en[i]=0, or if active blink_mask[i]=1 during the blink "off" phase.
REQ-018 Decode table: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-019 Outputs shall be registered; seg_display and seg_position reflect counter state with exactly 1-cycle latency, and frame_done is aligned to that output timing.
REQ-020 Double buffering: load writes the pending registers only; the active registers shall copy pending on the cycle digit 7's slot ends, so a frame never shows mixed data.
REQ-021 Multiple loads within one frame: the last one wins.
REQ-022 A load on the same cycle as the frame boundary: active takes the old pending value, pending takes the new value, and the new data appears one frame later.
REQ-023 No load: the active registers re-copy unchanged pending, so the display is stable indefinitely.
REQ-024 At most one seg_position bit shall be low in any cycle, with no exceptions.

Reset
REQ-025 While rst=0: all counters=0, pending and active registers=0, seg_display=7'h00, seg_position=8'hFF, frame_done=0, held asynchronously.
REQ-026 Reset mid-frame shall abort the scan immediately; after release the scan restarts at digit 0, slot count 0, blink phase "on".
REQ-027 After reset, digit_en=0 everywhere, so all digits stay dark until a load is followed by a frame boundary.

Verification (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-028 Reset check: hold rst=0 for several clocks, then release -> seg_position=FF, seg_display=00, no frame_done for the first 32 cycles.
REQ-029 Basic scan: load data=32'h76543210, en=FF, mask=00; wait for one frame boundary -> per slot, 1 blank cycle then 3 cycles of position ~(1<<i) with codes 7E,30,6D,79,33,5B,5F,70; frame_done every 32 cycles.
REQ-030 Double buffer: load 32'h11111111 mid-frame after the boundary in REQ-029 -> the rest of the current frame still shows the old digits, and the next frame shows all 30.
REQ-031 Blink: mask=01, en=FF -> digit 0 lit in frames 0-1, dark in frames 2-3, repeating; the other digits are always lit.
REQ-032 Enable, boundary-coincident load: en=0x80 -> only seg_position=7F is ever asserted; a load on the frame_done cycle takes effect one frame later.
REQ-033 Mid-scan reset: assert rst=0 during digit 5 -> outputs go to FF/00 asynchronously; after release the first lit slot is digit 0, only after a new load plus boundary.
